// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Owns the 8-LED bank. A free-running step tick advances one of four display
//   patterns. A debounced push-button cycles the mode. An external requester can
//   take over the bank through ovr_req/ovr_gnt.
//
// Parameters
//   TICK_DIV  clk cycles per pattern step (>= 2)
//   DEB_CYC   consecutive stable synced cycles needed to accept a new button level
//
// Ports
//   clk       system clock
//   rst       synchronous, active-high reset
//   btn       raw push-button, active-high, asynchronous to clk
//   ovr_req   override request
//   ovr_leds  LED value shown while override is granted
//   ovr_gnt   override granted (ovr_req delayed by one cycle)
//   mode      current mode: 0 ROTATE, 1 COUNT, 2 BOUNCE, 3 FLASH
//   leds      registered LED drive
module led_pattern_sequencer #(
    parameter int TICK_DIV = 12_500_000,
    parameter int DEB_CYC  = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       ovr_req,
    input  logic [7:0] ovr_leds,
    output logic       ovr_gnt,
    output logic [1:0] mode,
    output logic [7:0] leds
);

    localparam int SYNC_STAGES = 2;
    localparam int TICK_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DEB_W       = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);

    typedef enum logic [1:0] {
        M_ROTATE = 2'd0,
        M_COUNT  = 2'd1,
        M_BOUNCE = 2'd2,
        M_FLASH  = 2'd3
    } mode_t;

    // ------------------------------------------------------------------
    // Button synchroniser chain
    // ------------------------------------------------------------------
    logic sync_reg [SYNC_STAGES];
    logic btn_sync;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= btn;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign btn_sync = sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debouncer: the accepted level flips only after the synced level has
    // disagreed with it for DEB_CYC cycles in a row; any agreement restarts.
    // ------------------------------------------------------------------
    logic [DEB_W-1:0] deb_cnt_reg, deb_cnt_next;
    logic             deb_level_reg, deb_level_next;
    logic             deb_prev_reg;
    logic             press;

    always_comb begin
        deb_cnt_next   = deb_cnt_reg;
        deb_level_next = deb_level_reg;
        if (btn_sync != deb_level_reg) begin
            if (deb_cnt_reg == DEB_LAST) begin
                deb_level_next = btn_sync;
                deb_cnt_next   = '0;
            end else begin
                deb_cnt_next = deb_cnt_reg + DEB_W'(1);
            end
        end else begin
            deb_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt_reg   <= '0;
            deb_level_reg <= 1'b0;
            deb_prev_reg  <= 1'b0;
        end else begin
            deb_cnt_reg   <= deb_cnt_next;
            deb_level_reg <= deb_level_next;
            deb_prev_reg  <= deb_level_reg;
        end
    end

    // One-cycle pulse on the rising edge of the accepted level.
    assign press = deb_level_reg & ~deb_prev_reg;

    // ------------------------------------------------------------------
    // Mode FSM, tick counter and pattern generator
    // ------------------------------------------------------------------
    mode_t             mode_reg, mode_next;
    logic [TICK_W-1:0] tick_cnt_reg, tick_cnt_next;
    logic [7:0]        pattern_reg, pattern_next;
    logic              dir_left_reg, dir_left_next;
    logic              ovr_gnt_reg;
    logic [7:0]        leds_reg;
    logic              tick;

    assign tick = (tick_cnt_reg == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg     <= M_ROTATE;
            tick_cnt_reg <= '0;
            pattern_reg  <= 8'h01;
            dir_left_reg <= 1'b1;
            ovr_gnt_reg  <= 1'b0;
            leds_reg     <= 8'h01;
        end else begin
            mode_reg     <= mode_next;
            tick_cnt_reg <= tick_cnt_next;
            pattern_reg  <= pattern_next;
            dir_left_reg <= dir_left_next;
            ovr_gnt_reg  <= ovr_req;
            leds_reg     <= ovr_gnt_reg ? ovr_leds : pattern_reg;
        end
    end

    always_comb begin
        mode_next     = mode_reg;
        tick_cnt_next = tick_cnt_reg;
        pattern_next  = pattern_reg;
        dir_left_next = dir_left_reg;

        if (ovr_gnt_reg) begin
            // Granted: everything frozen, presses dropped.
        end else if (press) begin
            // A press outranks a coincident tick: restart the new mode cleanly.
            unique case (mode_reg)
                M_ROTATE: mode_next = M_COUNT;
                M_COUNT:  mode_next = M_BOUNCE;
                M_BOUNCE: mode_next = M_FLASH;
                default:  mode_next = M_ROTATE;
            endcase
            unique case (mode_next)
                M_COUNT: pattern_next = 8'h00;
                M_FLASH: pattern_next = 8'hFF;
                default: pattern_next = 8'h01;
            endcase
            tick_cnt_next = '0;
            dir_left_next = 1'b1;
        end else begin
            tick_cnt_next = tick ? '0 : tick_cnt_reg + TICK_W'(1);
            if (tick) begin
                unique case (mode_reg)
                    M_ROTATE: pattern_next = {pattern_reg[6:0], pattern_reg[7]};
                    M_COUNT:  pattern_next = pattern_reg + 8'd1;
                    M_BOUNCE: begin
                        // Turn around on reaching an end so each end shows once.
                        if (dir_left_reg) begin
                            if (pattern_reg == 8'h80) begin
                                pattern_next  = 8'h40;
                                dir_left_next = 1'b0;
                            end else begin
                                pattern_next = pattern_reg << 1;
                            end
                        end else begin
                            if (pattern_reg == 8'h01) begin
                                pattern_next  = 8'h02;
                                dir_left_next = 1'b1;
                            end else begin
                                pattern_next = pattern_reg >> 1;
                            end
                        end
                    end
                    default:  pattern_next = ~pattern_reg;
                endcase
            end
        end
    end

    assign ovr_gnt = ovr_gnt_reg;
    assign mode    = mode_reg;
    assign leds    = leds_reg;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
module tb_led_pattern_sequencer;

    localparam int TICK_DIV = 4;
    localparam int DEB_CYC  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic       ovr_req;
    logic [7:0] ovr_leds;
    logic       ovr_gnt;
    logic [1:0] mode;
    logic [7:0] leds;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    led_pattern_sequencer #(.TICK_DIV(TICK_DIV), .DEB_CYC(DEB_CYC)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .ovr_req  (ovr_req),
        .ovr_leds (ovr_leds),
        .ovr_gnt  (ovr_gnt),
        .mode     (mode),
        .leds     (leds)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: pattern is a closed-form function of mode and the
    // number of steps taken since the mode was entered.
    // ------------------------------------------------------------------
    int  m_mode, m_k, m_phase;
    bit  m_gnt, m_deb, m_deb_prev;
    int  m_leds;
    bit  btn_h1, btn_h2;
    bit  dq[$];

    function automatic int pat(input int md, input int k);
        int p;
        case (md)
            0: return 1 << (k % 8);
            1: return k % 256;
            2: begin
                p = k % 14;
                return (p < 8) ? (1 << p) : (1 << (14 - p));
            end
            default: return ((k % 2) == 0) ? 255 : 0;
        endcase
    endfunction

    always @(posedge clk) begin
        bit d, all_diff, prs;
        if (rst) begin
            m_mode = 0; m_k = 0; m_phase = 0; m_gnt = 0;
            m_deb = 0; m_deb_prev = 0; m_leds = 8'h01;
            btn_h1 = 0; btn_h2 = 0;
            dq.delete();
            for (int i = 0; i < DEB_CYC; i++) dq.push_back(1'b0);
        end else begin
            m_leds = m_gnt ? int'(ovr_leds) : pat(m_mode, m_k);
            prs = m_deb && !m_deb_prev;
            if (!m_gnt) begin
                if (prs) begin
                    m_mode = (m_mode + 1) % 4; m_k = 0; m_phase = 0;
                end else if (m_phase == TICK_DIV - 1) begin
                    m_k++; m_phase = 0;
                end else begin
                    m_phase++;
                end
            end
            m_gnt = ovr_req;
            // Debounce input is the button as sampled two edges ago.
            d = btn_h2;
            dq.push_back(d);
            void'(dq.pop_front());
            m_deb_prev = m_deb;
            all_diff = 1'b1;
            foreach (dq[i]) if (dq[i] == m_deb) all_diff = 1'b0;
            if (all_diff) m_deb = d;
            btn_h2 = btn_h1;
            btn_h1 = btn;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_leds", int'(leds), m_leds);
            chk("cyc_mode", int'(mode), m_mode);
            chk("cyc_gnt", int'(ovr_gnt), int'(m_gnt));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_btn(input int hi, input int lo);
        $display("txn press hi=%0d lo=%0d mode_before=%0d", hi, lo, m_mode);
        btn = 1'b1;
        cyc(hi);
        btn = 1'b0;
        cyc(lo);
    endtask

    initial begin
        int n;
        rst = 1'b1; btn = 1'b0; ovr_req = 1'b0; ovr_leds = 8'h00;
        cyc(2);
        chk_on = 1'b1;
        $display("txn reset");
        chk("rst_leds", int'(leds), 8'h01);
        chk("rst_mode", int'(mode), 0);
        chk("rst_gnt", int'(ovr_gnt), 0);

        // 1: free-run rotate; 9 steps after 40 edges, 10 after 41.
        rst = 1'b0;
        cyc(40);
        chk("rot40_leds", int'(leds), 8'h02);
        cyc(1);
        chk("rot41_leds", int'(leds), 8'h04);

        // 2: short glitch rejected, long press accepted.
        $display("txn glitch 2 cycles");
        btn = 1'b1; cyc(2); btn = 1'b0; cyc(10);
        chk("glitch_mode", int'(mode), 0);
        $display("txn press hi=6 to COUNT");
        btn = 1'b1; cyc(6); btn = 1'b0; cyc(2);
        chk("count_mode", int'(mode), 1);
        chk("count_init", int'(leds), 8'h00);
        cyc(1100);

        // 3: bounce then flash.
        press_btn(6, 6);
        chk("bounce_mode", int'(mode), 2);
        cyc(70);
        press_btn(6, 6);
        chk("flash_mode", int'(mode), 3);
        cyc(20);

        // 4: press lands in the tick cycle.
        n = 0;
        while (m_phase != 2 && n < 10) begin cyc(1); n++; end
        chk("align_wait", int'(m_phase == 2), 1);
        $display("txn aligned press");
        btn = 1'b1; cyc(6); btn = 1'b0; cyc(2);
        chk("align_mode", int'(mode), 0);
        chk("align_leds", int'(leds), 8'h01);
        cyc(10);

        // 5: override.
        $display("txn override A5");
        ovr_leds = 8'hA5; ovr_req = 1'b1;
        cyc(1);
        chk("ovr_gnt", int'(ovr_gnt), 1);
        cyc(1);
        chk("ovr_leds", int'(leds), 8'hA5);
        press_btn(6, 6);
        chk("ovr_mode_hold", int'(mode), 0);
        ovr_req = 1'b0;
        cyc(20);

        // 6: reset mid-bounce moving right with override active.
        press_btn(6, 6);
        press_btn(6, 6);
        chk("b2_mode", int'(mode), 2);
        n = 0;
        while (!((m_k % 14) >= 8) && n < 200) begin cyc(1); n++; end
        chk("right_wait", int'((m_k % 14) >= 8), 1);
        $display("txn override then reset");
        ovr_leds = 8'h3C; ovr_req = 1'b1;
        cyc(2);
        rst = 1'b1; ovr_req = 1'b0;
        cyc(1);
        chk("rst2_leds", int'(leds), 8'h01);
        chk("rst2_mode", int'(mode), 0);
        chk("rst2_gnt", int'(ovr_gnt), 0);
        rst = 1'b0;

        // 7: random traffic.
        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 3))
                0, 1: press_btn($urandom_range(1, 7), $urandom_range(1, 8));
                2: begin
                    ovr_leds = 8'($urandom);
                    n = $urandom_range(1, 12);
                    $display("txn override leds=%02h len=%0d", ovr_leds, n);
                    ovr_req = 1'b1;
                    if ($urandom_range(0, 1) == 1) btn = 1'b1;
                    cyc(n);
                    ovr_req = 1'b0;
                    btn = 1'b0;
                    cyc($urandom_range(1, 6));
                end
                default: begin
                    n = $urandom_range(1, 40);
                    $display("txn idle %0d", n);
                    cyc(n);
                end
            endcase
        end
        cyc(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
